// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// Hits are answered combinationally from the tag/data arrays. Cacheable misses
// fetch a whole line through sequential SRAM-like word reads. Addresses with
// bit 30 set bypass the arrays as single-word reads.
//
// Handshake: a request is accepted on a rising edge where inst_req and
// inst_addr_ok are both 1. inst_addr is held stable while inst_req is 1.
// inst_data_ok marks one read word on inst_rdata, and words return in
// acceptance order. Fetch side: ien is held with a stable iaddr_i until the
// one-cycle inst_ok pulse, or until pc_changed abandons the fetch.
module icache_dm #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ien,
  input  logic        pc_changed,
  input  logic [31:0] iaddr_i,
  output logic [31:0] idata_i,
  output logic        inst_ok,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic [1:0]  dbg_state
);

  localparam int IDX = $clog2(LINES);
  localparam int WB  = $clog2(WORDS);
  localparam int OFF = WB + 2;
  localparam int TW  = 32 - OFF - IDX;
  localparam int CW  = WB + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_UNC    = 2'd2;

  // Control state
  logic [1:0]     state_q;
  logic [31:0]    addr_q;    // line base during a refill, word address when uncached
  logic [CW-1:0]  req_cnt;   // refill requests accepted so far (0..WORDS)
  logic [WB-1:0]  rsp_cnt;   // refill words received so far
  logic           kill_q;    // uncached fetch was abandoned
  logic           sent_q;    // uncached request accepted
  logic [LINES-1:0] valid_q;

  // Arrays (not reset; validity lives in valid_q)
  logic [TW-1:0]  tag_mem  [LINES];
  logic [31:0]    data_mem [LINES*WORDS];

  // Fetch address decode
  logic [31:0]    pa;
  logic           cacheable;
  logic [IDX-1:0] pa_idx;
  logic [TW-1:0]  pa_tag;
  logic [WB-1:0]  pa_word;
  logic [IDX-1:0] line_idx;
  logic [TW-1:0]  line_tag;
  logic           hit_idle;
  logic           refill_dok;
  logic           unc_ok;
  logic           unused_addr_bits;

  assign pa        = {3'b000, iaddr_i[28:0]};
  assign cacheable = !iaddr_i[30];
  assign pa_idx    = pa[OFF+IDX-1:OFF];
  assign pa_tag    = pa[31:OFF+IDX];
  assign pa_word   = pa[OFF-1:2];
  assign line_idx  = addr_q[OFF+IDX-1:OFF];
  assign line_tag  = addr_q[31:OFF+IDX];

  // Bits 31 and 29 are dropped by the fixed virtual-to-physical mapping.
  assign unused_addr_bits = iaddr_i[31] ^ iaddr_i[29];

  assign hit_idle   = (state_q == S_IDLE) && ien && cacheable &&
                      valid_q[pa_idx] && (tag_mem[pa_idx] == pa_tag);
  assign refill_dok = (state_q == S_REFILL) && inst_data_ok;
  assign unc_ok     = (state_q == S_UNC) && inst_data_ok && !kill_q && !pc_changed;

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'd0;
  assign dbg_state  = state_q;

  // Bus request side: refill walks the line word by word, uncached sends once
  always_comb begin
    inst_req  = 1'b0;
    inst_addr = 32'd0;
    case (state_q)
      S_REFILL: begin
        inst_req  = !req_cnt[CW-1];
        inst_addr = {addr_q[31:OFF], req_cnt[WB-1:0], 2'b00};
      end
      S_UNC: begin
        inst_req  = !sent_q;
        inst_addr = addr_q;
      end
      default: begin
        inst_req  = 1'b0;
        inst_addr = 32'd0;
      end
    endcase
  end

  // Fetch completion: hit in IDLE, or a live uncached response
  always_comb begin
    inst_ok = hit_idle | unc_ok;
    idata_i = 32'd0;
    if (hit_idle) begin
      idata_i = data_mem[{pa_idx, pa_word}];
    end else if (unc_ok) begin
      idata_i = inst_rdata;
    end
  end

  // Controller: miss/uncached dispatch, refill counters, line validation
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      req_cnt <= '0;
      rsp_cnt <= '0;
      kill_q  <= 1'b0;
      sent_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ien && !hit_idle) begin
            if (cacheable) begin
              addr_q  <= {pa[31:OFF], {OFF{1'b0}}};
              req_cnt <= '0;
              rsp_cnt <= '0;
              state_q <= S_REFILL;
            end else begin
              addr_q  <= pa;
              kill_q  <= 1'b0;
              sent_q  <= 1'b0;
              state_q <= S_UNC;
            end
          end
        end
        S_REFILL: begin
          // Request and response counters advance independently; a refill
          // always runs to completion even if the fetch is abandoned.
          if (inst_req && inst_addr_ok) begin
            req_cnt <= req_cnt + CW'(1);
          end
          if (inst_data_ok) begin
            rsp_cnt <= rsp_cnt + WB'(1);
            if (&rsp_cnt) begin
              valid_q[line_idx] <= 1'b1;
              state_q           <= S_IDLE;
            end
          end
        end
        S_UNC: begin
          if (inst_req && inst_addr_ok) begin
            sent_q <= 1'b1;
          end
          if (pc_changed) begin
            kill_q <= 1'b1;
          end
          if (inst_data_ok) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Array writes: each refill word lands in its slot; the tag goes in with the last word
  always_ff @(posedge clk) begin
    if (refill_dok) begin
      data_mem[{line_idx, rsp_cnt}] <= inst_rdata;
      if (&rsp_cnt) begin
        tag_mem[line_idx] <= line_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized bench for icache_dm with an SRAM-like memory
// slave, an expected-request queue and a line-level cache model.
module tb_icache_dm;

  localparam int LINES = 64;
  localparam int WORDS = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ien = 1'b0;
  logic        pc_changed = 1'b0;
  logic [31:0] iaddr_i = 32'd0;
  logic [31:0] idata_i;
  logic        inst_ok;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata = 32'd0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ien          (ien),
    .pc_changed   (pc_changed),
    .iaddr_i      (iaddr_i),
    .idata_i      (idata_i),
    .inst_ok      (inst_ok),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .dbg_state    (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];          // physical addresses the DUT must request, in order
  int acc_cnt = 0;                // accepted requests
  int dok_cnt = 0;                // responses delivered
  int last_dok_cyc = -10;

  bit mdl_valid [LINES];
  int mdl_tag   [LINES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents as seen through the bridge
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ {a[7:0], a[15:8]}} ^ 32'h0F1E_2D3C;
  endfunction

  // ---------------- memory slave ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t rsp_q[$];

  always begin
    @(posedge clk);
    #1;
    if (!rstn) begin
      rsp_q.delete();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
    end else begin
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_fn(rsp_q[0].addr);
        void'(rsp_q.pop_front());
      end else begin
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
      end
      if (inst_req && $urandom_range(0, 3) != 0) begin
        rsp_t r;
        inst_addr_ok = 1'b1;
        r.addr = inst_addr;
        r.due  = cyc + int'($urandom_range(1, 4));
        rsp_q.push_back(r);
      end else begin
        inst_addr_ok = 1'b0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (inst_req && inst_addr_ok) begin
        logic [31:0] e;
        acc_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("req_addr", inst_addr, e);
      end
      if (inst_data_ok) begin
        dok_cnt++;
        last_dok_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] phys(input logic [31:0] a);
    return {3'b000, a[28:0]};
  endfunction

  function automatic int line_of(input logic [31:0] pa);
    return int'(pa / 32'(WORDS * 4));
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    int ln;
    ln = line_of(phys(a));
    return !a[30] && mdl_valid[ln % LINES] && (mdl_tag[ln % LINES] == ln / LINES);
  endfunction

  task automatic mdl_fill(input logic [31:0] a);
    int ln;
    ln = line_of(phys(a));
    mdl_valid[ln % LINES] = 1'b1;
    mdl_tag[ln % LINES]   = ln / LINES;
  endtask

  task automatic push_line(input logic [31:0] a);
    int ln;
    ln = line_of(phys(a));
    for (int w = 0; w < WORDS; w++) exp_q.push_back(32'(ln * WORDS * 4 + w * 4));
  endtask

  // One fetch to completion; returns the number of bus requests it caused
  task automatic fetch(input logic [31:0] a, output int nreq);
    logic [31:0] pa;
    bit unc, hit, done;
    int start_acc, start_dok, n;
    pa  = phys(a);
    unc = a[30];
    hit = mdl_hit(a);
    if (unc) exp_q.push_back(pa);
    else if (!hit) push_line(a);
    start_acc = acc_cnt;
    start_dok = dok_cnt;
    ien = 1'b1;
    iaddr_i = a;
    done = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      sample();
      if (inst_ok) begin
        done = 1'b1;
        check("fetch_data", idata_i, mem_fn(pa));
        if (hit) check("hit_latency", 32'(n), 32'd0);
        else if (unc) check("unc_same_cycle", 32'(inst_data_ok), 32'd1);
        else begin
          check("miss_latency", 32'(cyc), 32'(last_dok_cyc + 1));
          check("refill_words", 32'(dok_cnt - start_dok), 32'(WORDS));
        end
      end
      n++;
      step();
    end
    ien = 1'b0;
    check("fetch_done", 32'(done), 32'd1);
    check("req_all_seen", 32'(exp_q.size()), 32'd0);
    nreq = acc_cnt - start_acc;
    if (!unc && !hit) mdl_fill(a);
  endtask

  // Uncached fetch abandoned after its request is accepted
  task automatic fetch_abandon_unc(input logic [31:0] a);
    int start_acc, n, ok_seen;
    exp_q.push_back(phys(a));
    start_acc = acc_cnt;
    ien = 1'b1;
    iaddr_i = a;
    ok_seen = 0;
    n = 0;
    while (acc_cnt == start_acc && n < 100) begin
      sample();
      if (inst_ok) ok_seen++;
      n++;
      if (acc_cnt == start_acc) step();
    end
    check("unc_abandon_sent", 32'(acc_cnt - start_acc), 32'd1);
    step();
    pc_changed = 1'b1;
    ien = 1'b0;
    sample();
    if (inst_ok) ok_seen++;
    step();
    pc_changed = 1'b0;
    n = 0;
    while (n < 100) begin
      sample();
      if (inst_ok) ok_seen++;
      n++;
      if (dbg_state == 2'd0 && rsp_q.size() == 0) break;
      step();
    end
    step();
    check("unc_abandon_drained", 32'(rsp_q.size() == 0 && n < 100), 32'd1);
    check("unc_abandon_no_ok", 32'(ok_seen), 32'd0);
    check("req_all_seen", 32'(exp_q.size()), 32'd0);
  endtask

  // Refill abandoned after two responses; new fetch lies in the same line
  task automatic fetch_abandon_refill(input logic [31:0] a, input logic [31:0] a2);
    int start_acc, start_dok, n, early_ok;
    bit done;
    push_line(a);
    start_acc = acc_cnt;
    start_dok = dok_cnt;
    ien = 1'b1;
    iaddr_i = a;
    early_ok = 0;
    n = 0;
    while ((dok_cnt - start_dok) < 2 && n < 200) begin
      sample();
      if (inst_ok) early_ok++;
      n++;
      if ((dok_cnt - start_dok) < 2) step();
    end
    step();
    pc_changed = 1'b1;
    iaddr_i = a2;
    step();
    pc_changed = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      sample();
      if (inst_ok) begin
        done = 1'b1;
        check("abandon_refill_data", idata_i, mem_fn(phys(a2)));
        check("abandon_refill_latency", 32'(cyc), 32'(last_dok_cyc + 1));
        check("abandon_refill_words", 32'(dok_cnt - start_dok), 32'(WORDS));
      end
      n++;
      step();
    end
    ien = 1'b0;
    check("abandon_refill_done", 32'(done), 32'd1);
    check("abandon_refill_early_ok", 32'(early_ok), 32'd0);
    check("abandon_refill_reqs", 32'(acc_cnt - start_acc), 32'(WORDS));
    check("req_all_seen", 32'(exp_q.size()), 32'd0);
    mdl_fill(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(inst_req), 32'd0);
    check({tag, "_ok"},    32'(inst_ok), 32'd0);
    check({tag, "_idata"}, idata_i, 32'd0);
    check({tag, "_addr"},  inst_addr, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Reset asserted in the middle of a refill
  task automatic reset_mid_refill(input logic [31:0] a);
    int start_dok, n;
    push_line(a);
    start_dok = dok_cnt;
    ien = 1'b1;
    iaddr_i = a;
    n = 0;
    while ((dok_cnt - start_dok) < 2 && n < 200) begin
      sample();
      n++;
      if ((dok_cnt - start_dok) < 2) step();
    end
    step();
    rstn = 1'b0;
    ien = 1'b0;
    exp_q.delete();
    foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
    sample();
    check_reset_outputs("midreset");
    repeat (3) step();
    rstn = 1'b1;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int nr;
    logic [31:0] a;
    logic [2:0]  hi;
    logic [28:0] lo;

    foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    check_reset_outputs("reset");
    check("tie_wr",    32'(inst_wr), 32'd0);
    check("tie_size",  32'(inst_size), 32'd2);
    check("tie_wdata", inst_wdata, 32'd0);
    step();
    rstn = 1'b1;
    step();

    // Cold miss, then a hit in the same line
    fetch(32'h9FC0_0000, nr);
    check("cold_miss_reqs", 32'(nr), 32'd4);
    fetch(32'h9FC0_0008, nr);
    check("hit_reqs", 32'(nr), 32'd0);

    // Uncached twice: no fill, so each fetch goes to the bus
    fetch(32'h5FC0_0010, nr);
    check("unc_reqs_1", 32'(nr), 32'd1);
    fetch(32'h5FC0_0010, nr);
    check("unc_reqs_2", 32'(nr), 32'd1);

    // Conflict eviction on index 0
    fetch(32'h9FC0_0400, nr);
    check("conflict_reqs_1", 32'(nr), 32'd4);
    fetch(32'h9FC0_0000, nr);
    check("conflict_reqs_2", 32'(nr), 32'd4);

    // Abandoned uncached read, then a cached fetch
    fetch_abandon_unc(32'h5FC0_0020);
    fetch(32'h9FC0_0004, nr);
    check("after_unc_abandon_reqs", 32'(nr), 32'd0);

    // Abandoned refill; the line must still become valid
    fetch_abandon_refill(32'h9FC0_0040, 32'h9FC0_004C);
    fetch(32'h9FC0_0044, nr);
    check("after_refill_abandon_reqs", 32'(nr), 32'd0);

    // Reset mid-refill leaves the line invalid
    reset_mid_refill(32'h9FC0_0080);
    fetch(32'h9FC0_0080, nr);
    check("after_reset_reqs", 32'(nr), 32'd4);
    fetch(32'h9FC0_0000, nr);
    check("reset_cleared_valid", 32'(nr), 32'd4);

    // Randomized fetch stream over a few tags and indexes, aliased high bits
    for (int i = 0; i < 200; i++) begin
      hi = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) != 0) hi[1] = 1'b0;
      lo = 29'h1FC0_0000
         + 29'($urandom_range(0, 2) * LINES * WORDS * 4)
         + 29'($urandom_range(0, 7) * WORDS * 4)
         + 29'($urandom_range(0, WORDS - 1) * 4);
      a = {hi, lo};
      fetch(a, nr);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
